mem_port_arbiter: RTL and testbench

- Shares one single-ported memory between the instruction-fetch path (port I, read-only) and the load/store path (port D, read/write with byte enables).
- Round-robin arbitration; one outstanding memory transaction at a time.
- Per-access watchdog aborts transactions the memory never acknowledges.
- Sits between the CPU datapath (PC/instruction fetch and data access) and the unified memory model.

---
 rtl/mem_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one single-ported memory between instruction fetch
// (port I, read-only) and load/store (port D). Round-robin between the ports,
// one memory transaction in flight, and a per-access watchdog that aborts
// accesses the memory never acknowledges.
module mem_port_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              last_d_q, last_d_d;   // 1: port D was granted last
  logic              gnt_d_q, gnt_d_d;     // 1: current access belongs to D
  logic [TO_W-1:0]   wdog_q, wdog_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       i_rdata_q, i_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              i_done_q, i_done_d;
  logic              d_done_q, d_done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              pick_d;

  // Next-state and registered-output logic for the IDLE/ACCESS/RESP machine.
  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    gnt_d_d     = gnt_d_q;
    wdog_d      = wdog_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;
    err_d       = 1'b0;
    // On a tie, D wins only if I was served last.
    pick_d      = d_req && (!i_req || !last_d_q);

    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          gnt_d_d     = pick_d;
          last_d_d    = pick_d;
          mem_req_d   = 1'b1;
          mem_we_d    = pick_d && d_we;
          mem_addr_d  = pick_d ? d_addr : i_addr;
          mem_wdata_d = pick_d ? d_wdata : 32'h0;
          // Reads always fetch the full word; only stores honour d_be.
          mem_be_d    = (pick_d && d_we) ? d_be : 4'hF;
          wdog_d      = '0;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          if (gnt_d_q) begin
            d_rdata_d = mem_rdata;
            d_done_d  = 1'b1;
          end else begin
            i_rdata_d = mem_rdata;
            i_done_d  = 1'b1;
          end
          state_d = RESP;
        end else if (wdog_q == TO_LAST) begin
          // Abort: the requester still gets its done pulse, flagged by err.
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          if (gnt_d_q) begin
            d_rdata_d = 32'h0;
            d_done_d  = 1'b1;
          end else begin
            i_rdata_d = 32'h0;
            i_done_d  = 1'b1;
          end
          state_d = RESP;
        end else begin
          wdog_d = wdog_q + TO_W'(1);
        end
      end
      RESP: begin
        // Requests are not sampled here so a requester can drop req in time.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drops mem_req at once and loses the access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b1;
      gnt_d_q     <= 1'b0;
      wdog_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_be_q    <= 4'h0;
      i_rdata_q   <= 32'h0;
      d_rdata_q   <= 32'h0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      gnt_d_q     <= gnt_d_d;
      wdog_q      <= wdog_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign i_rdata   = i_rdata_q;
  assign i_done    = i_done_q;
  assign d_rdata   = d_rdata_q;
  assign d_done    = d_done_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign err       = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter. Stimulus pushes expected memory
// transactions and done responses; monitors pop and compare on every
// mem_req rise and done pulse. A second instance with TIMEOUT=4 covers abort.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main instance (TIMEOUT=16)
  logic        i_req = 0, d_req = 0, d_we = 0;
  logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0;
  logic [3:0]  d_be = 0;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic        i_done, d_done, mem_req, mem_we, err, busy;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = 0;
  logic        mem_ready = 0;

  // timeout instance (TIMEOUT=4)
  logic        t_d_req = 0;
  logic [31:0] t_d_addr = 0;
  logic [31:0] t_i_rdata, t_d_rdata, t_mem_addr, t_mem_wdata;
  logic        t_i_done, t_d_done, t_mem_req, t_mem_we, t_err, t_busy;
  logic [3:0]  t_mem_be;
  logic [31:0] t_mem_rdata = 0;
  logic        t_mem_ready = 0;
  logic        t_ready_en = 0;

  mem_port_arbiter #(.TIMEOUT(16), .TO_W(8)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .err(err), .busy(busy)
  );

  mem_port_arbiter #(.TIMEOUT(4), .TO_W(3)) dut_to (
    .clk(clk), .rst(rst),
    .i_req(1'b0), .i_addr(32'h0), .i_rdata(t_i_rdata), .i_done(t_i_done),
    .d_req(t_d_req), .d_we(1'b0), .d_addr(t_d_addr), .d_wdata(32'h0), .d_be(4'h0),
    .d_rdata(t_d_rdata), .d_done(t_d_done),
    .mem_req(t_mem_req), .mem_we(t_mem_we), .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata),
    .mem_be(t_mem_be), .mem_rdata(t_mem_rdata), .mem_ready(t_mem_ready),
    .err(t_err), .busy(t_busy)
  );

  typedef struct {
    bit          unit;
    bit          port_d;
    logic [31:0] rdata;
    logic        err;
  } done_exp_t;

  typedef struct {
    bit          unit;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          len;   // expected mem_req high cycles, 0 = not checked
  } mem_exp_t;

  done_exp_t dq[$];
  mem_exp_t  mq[$];
  int checks = 0;
  int errors = 0;

  function automatic void chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s", nm);
  endfunction

  function automatic void exp_mem(input bit u, input logic we, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [3:0] be, input int len);
    mem_exp_t e;
    e.unit = u; e.we = we; e.addr = a; e.wdata = wd; e.be = be; e.len = len;
    mq.push_back(e);
  endfunction

  function automatic void exp_done(input bit u, input bit pd, input logic [31:0] rd, input logic er);
    done_exp_t e;
    e.unit = u; e.port_d = pd; e.rdata = rd; e.err = er;
    dq.push_back(e);
  endfunction

  // write data only matters for stores
  function automatic logic [71:0] mem_vec(input bit u, input logic we, input logic [31:0] a,
                                          input logic [31:0] wd, input logic [3:0] be);
    return {3'b0, u, we, a, be, (we ? wd : 32'h0)};
  endfunction

  function automatic void pop_done(input bit u, input bit pd, input logic [31:0] rd, input logic er,
                                   input logic bz);
    done_exp_t e;
    if (dq.size() == 0) begin
      fail_now($sformatf("unexpected_done unit=%0d port_d=%0d rdata=%h err=%0d", u, pd, rd, er));
    end else begin
      e = dq.pop_front();
      chk("done_resp", {36'b0, u, pd, rd, er, bz}, {36'b0, e.unit, e.port_d, e.rdata, e.err, 1'b1});
    end
  endfunction

  // main memory model: answers after `delay` ACCESS cycles, applies byte enables
  logic [31:0] mem [0:255];
  int  delay = 0;
  int  acc_cnt = 0;
  bit  spur = 0;

  always @(negedge clk) begin
    if (mem_req) begin
      if (acc_cnt == delay) begin
        mem_ready = 1'b1;
        mem_rdata = mem[mem_addr[9:2]];
        if (mem_we) begin
          for (int b = 0; b < 4; b++)
            if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
        end
      end else begin
        mem_ready = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
      end
      acc_cnt++;
    end else begin
      mem_ready = spur;
      mem_rdata = 32'hBAD0_BAD0;
      acc_cnt   = 0;
    end
  end

  always @(negedge clk) begin
    t_mem_ready = t_mem_req && t_ready_en;
    t_mem_rdata = t_mem_ready ? 32'h9999_0000 : 32'h0;
  end

  // monitor: main instance
  bit       m_prev = 0;
  int       m_len = 0;
  mem_exp_t m_cur;
  always @(negedge clk) begin
    if (mem_req && !m_prev) begin
      if (mq.size() == 0) begin
        fail_now($sformatf("unexpected_mem_req addr=%h", mem_addr));
        m_cur.unit = 0; m_cur.we = mem_we; m_cur.addr = mem_addr;
        m_cur.wdata = mem_wdata; m_cur.be = mem_be; m_cur.len = 0;
      end else begin
        m_cur = mq.pop_front();
      end
      chk("mem_txn", mem_vec(0, mem_we, mem_addr, mem_wdata, mem_be),
          mem_vec(m_cur.unit, m_cur.we, m_cur.addr, m_cur.wdata, m_cur.be));
      m_len = 1;
    end else if (mem_req) begin
      chk("mem_stable", mem_vec(0, mem_we, mem_addr, mem_wdata, mem_be),
          mem_vec(m_cur.unit, m_cur.we, m_cur.addr, m_cur.wdata, m_cur.be));
      m_len++;
    end else if (m_prev && m_cur.len > 0) begin
      chk("mem_req_len", 72'(m_len), 72'(m_cur.len));
    end
    m_prev = mem_req;
    if (i_done) pop_done(0, 0, i_rdata, err, busy);
    if (d_done) pop_done(0, 1, d_rdata, err, busy);
  end

  // monitor: timeout instance
  bit       t_prev = 0;
  int       t_len = 0;
  mem_exp_t t_cur;
  always @(negedge clk) begin
    if (t_mem_req && !t_prev) begin
      if (mq.size() == 0) begin
        fail_now($sformatf("unexpected_t_mem_req addr=%h", t_mem_addr));
        t_cur.unit = 1; t_cur.we = t_mem_we; t_cur.addr = t_mem_addr;
        t_cur.wdata = t_mem_wdata; t_cur.be = t_mem_be; t_cur.len = 0;
      end else begin
        t_cur = mq.pop_front();
      end
      chk("t_mem_txn", mem_vec(1, t_mem_we, t_mem_addr, t_mem_wdata, t_mem_be),
          mem_vec(t_cur.unit, t_cur.we, t_cur.addr, t_cur.wdata, t_cur.be));
      t_len = 1;
    end else if (t_mem_req) begin
      t_len++;
    end else if (t_prev && t_cur.len > 0) begin
      chk("t_mem_req_len", 72'(t_len), 72'(t_cur.len));
    end
    t_prev = t_mem_req;
    if (t_i_done) pop_done(1, 0, t_i_rdata, t_err, t_busy);
    if (t_d_done) pop_done(1, 1, t_d_rdata, t_err, t_busy);
  end

  task automatic i_access(input logic [31:0] a);
    bit got = 0;
    @(negedge clk);
    i_addr = a;
    i_req  = 1'b1;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (i_done) got = 1;
    end
    if (!got) fail_now($sformatf("i_done_timeout addr=%h", a));
    i_req = 1'b0;
  endtask

  task automatic d_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be);
    bit got = 0;
    @(negedge clk);
    d_we = we; d_addr = a; d_wdata = wd; d_be = be;
    d_req = 1'b1;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (d_done) got = 1;
    end
    if (!got) fail_now($sformatf("d_done_timeout addr=%h", a));
    d_req = 1'b0;
  endtask

  task automatic t_access(input logic [31:0] a);
    bit got = 0;
    @(negedge clk);
    t_d_addr = a;
    t_d_req  = 1'b1;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (t_d_done) got = 1;
    end
    if (!got) fail_now($sformatf("t_d_done_timeout addr=%h", a));
    t_d_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit");
    $fatal(1, "time limit");
  end

  initial begin
    bit got;
    for (int w = 0; w < 256; w++) mem[w] = 32'h0;
    mem[8'h10] = 32'h2402_0005;   // 0x040
    mem[8'h20] = 32'hA5A5_0001;   // 0x080
    mem[8'h21] = 32'hA5A5_0002;   // 0x084
    mem[8'h40] = 32'h1111_2222;   // 0x100
    mem[8'h80] = 32'h3333_4444;   // 0x200
    mem[8'h81] = 32'h5555_6666;   // 0x204

    // reset state
    repeat (2) @(negedge clk);
    chk("reset_mem", {2'b0, mem_req, mem_we, mem_addr, mem_wdata, mem_be}, 72'h0);
    chk("reset_flags", {i_done, d_done, err, busy}, 72'h0);
    chk("reset_rdata", {i_rdata, d_rdata}, 72'h0);
    chk("reset_t", {t_d_rdata, t_i_done, t_d_done, t_err, t_busy, t_mem_req}, 72'h0);
    rst = 1'b0;

    // 1: fetch, memory answers one cycle after mem_req
    delay = 1;
    exp_mem(0, 0, 32'h40, 32'h0, 4'hF, 2);
    exp_done(0, 0, 32'h2402_0005, 0);
    i_access(32'h40);

    // 2: store with slow memory, then load back through the byte enables
    delay = 5;
    exp_mem(0, 1, 32'h100, 32'hCAFE_F00D, 4'b0011, 6);
    exp_done(0, 1, 32'h1111_2222, 0);
    d_access(1, 32'h100, 32'hCAFE_F00D, 4'b0011);
    delay = 0;
    exp_mem(0, 0, 32'h100, 32'h0, 4'hF, 1);
    exp_done(0, 1, 32'h1111_F00D, 0);
    d_access(0, 32'h100, 32'h0, 4'b0011);

    // 3: both ports from reset, held -> I, D, I, D
    do_reset();
    delay = 0;
    exp_mem(0, 0, 32'h80,  32'h0, 4'hF, 1);
    exp_mem(0, 0, 32'h200, 32'h0, 4'hF, 1);
    exp_mem(0, 0, 32'h84,  32'h0, 4'hF, 1);
    exp_mem(0, 0, 32'h204, 32'h0, 4'hF, 1);
    exp_done(0, 0, 32'hA5A5_0001, 0);
    exp_done(0, 1, 32'h3333_4444, 0);
    exp_done(0, 0, 32'hA5A5_0002, 0);
    exp_done(0, 1, 32'h5555_6666, 0);
    fork
      begin i_access(32'h80);  i_access(32'h84);  end
      begin d_access(0, 32'h200, 32'h0, 4'hF); d_access(0, 32'h204, 32'h0, 4'hF); end
    join

    // 4: timeout instance: one good load, then memory goes silent
    t_ready_en = 1;
    exp_mem(1, 0, 32'h300, 32'h0, 4'hF, 1);
    exp_done(1, 1, 32'h9999_0000, 0);
    t_access(32'h300);
    t_ready_en = 0;
    exp_mem(1, 0, 32'h304, 32'h0, 4'hF, 4);
    exp_done(1, 1, 32'h0, 1);
    t_access(32'h304);
    @(negedge clk);
    chk("t_idle_after_abort", {t_busy, t_err, t_d_done, t_mem_req}, 72'h0);

    // 5: reset in the 2nd ACCESS cycle
    delay = 10;
    exp_mem(0, 0, 32'h40, 32'h0, 4'hF, 0);
    @(negedge clk);
    i_addr = 32'h40;
    i_req  = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("async_rst_mem_req", {71'b0, mem_req}, 72'h0);
    i_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    delay = 0;
    exp_mem(0, 0, 32'h80,  32'h0, 4'hF, 1);
    exp_mem(0, 0, 32'h204, 32'h0, 4'hF, 1);
    exp_done(0, 0, 32'hA5A5_0001, 0);
    exp_done(0, 1, 32'h5555_6666, 0);
    fork
      i_access(32'h80);
      d_access(0, 32'h204, 32'h0, 4'hF);
    join

    // 6: i_req dropped right after grant; stray mem_ready outside ACCESS
    delay = 2;
    exp_mem(0, 0, 32'h84, 32'h0, 4'hF, 3);
    exp_done(0, 0, 32'hA5A5_0002, 0);
    @(negedge clk);
    i_addr = 32'h84;
    i_req  = 1'b1;
    @(negedge clk);
    i_req  = 1'b0;
    got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (i_done) got = 1;
    end
    if (!got) fail_now("i_done_timeout_after_drop");
    spur = 1;
    repeat (5) @(negedge clk);
    spur = 0;
    chk("idle_after_drop", {i_rdata, 36'b0, busy, mem_req, i_done, err},
        {32'hA5A5_0002, 36'b0, 4'b0});

    repeat (3) @(negedge clk);
    chk("done_queue_empty", 72'(dq.size()), 72'h0);
    chk("mem_queue_empty", 72'(mq.size()), 72'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
